seven_seg_frame_decoder: RTL and testbench
==========================================

// Module: seven_seg_frame_decoder
// PURPOSE
// Listens to a multiplexed 7-segment bus (one-hot digit strobe plus abcdefgh segments) and rebuilds
// the displayed text as per-digit glyph codes. It is the receive end of the display driver interface.
// Used for on-board self-test: the driver's abcdefgh/digit outputs are looped back in the same clock domain.
// Publishes a complete frame once every digit has been sampled stably.
// PARAMETERS
// N_DIGITS       4   number of multiplexed digits observed; seg_digit bit i = slot i
// SETTLE_CYCLES  4   consecutive identical (digit,seg) cycles needed before sampling; range >= 1
// COUNT_W        16  width of frame_count
// PORTS
// clock          in   1            system clock; all inputs are synchronous to it
// reset_n        in   1            asynchronous, active-low reset
// seg_abcdefgh   in   8            segments: bit7=a ... bit1=g, bit0=h (dot); 1 = lit
// seg_digit      in   N_DIGITS     digit strobe: one-hot when valid, all-zero = blanking
// err_clear      in   1            synchronous clear of the sticky error flags
// chars          out  5*N_DIGITS   glyph code of slot i at chars[5*i +: 5]
// dots           out  N_DIGITS     dot (h) state of each slot
// frame_valid    out  1            1-cycle pulse when chars/dots are updated with a complete frame
// frame_changed  out  1            qualified by frame_valid; new frame differs from the previous one
// frame_count    out  COUNT_W      number of completed frames; wraps to 0
// err_onehot     out  1            sticky: stable seg_digit with more than one bit set
// err_pattern    out  1            sticky: stable segment pattern not in the glyph table
// BEHAVIOUR
// - Reset (async, reset_n=0): chars = every slot 5'd18 (space); dots = 0; frame_valid = 0;
//   frame_changed = 0; frame_count = 0; errors = 0; slot mask = 0; stable counter = 0.
// - Sampler: registers the previous (seg_digit, seg_abcdefgh).
//   - stable_cnt resets to 0 in any cycle where the sample differs from the previous one.
//   - Otherwise stable_cnt increments, saturating at SETTLE_CYCLES-1.
//   - A "dwell" is a run of identical samples. It is sampled once: in the cycle stable_cnt reaches
//     SETTLE_CYCLES-1 and the dwell has not already been sampled.
//   - The first cycle after a change counts as stable cycle 1.
// - At the sample point:
//   - seg_digit == 0: no action (blanking).
//   - seg_digit not one-hot: set err_onehot; no capture.
//   - Otherwise decode seg_abcdefgh[7:1] into an internal slot buffer, store bit0 as the dot, and
//     set that slot's mask bit.
// - Recapturing a slot already in the mask overwrites it; the last value wins, with no error.
// - Glyph table (bits a..g -> code):
//   0=1111110:0  1=0110000:1  2=1101101:2  3=1111001:3  4=0110011:4
//   5=1011011:5  6=1011111:6  7=1110000:7  8=1111111:8  9=1111011:9
//   A=1110111:10  b=0011111:11  C=1001110:12  d=0111101:13  E=1001111:14
//   F=1000111:15  G=1011110:16  P=1100111:17  space=0000000:18
//   anything else: code 31, and err_pattern is set.
// - Frame completion: when a capture makes the mask all ones, the next cycle shows:
//   - chars/dots loaded from the buffer, including the completing slot;
//   - frame_valid = 1 for exactly one cycle;
//   - frame_changed = (new chars/dots != previous outputs);
//   - frame_count incremented, with mod 2^COUNT_W wrap;
//   - mask cleared.
// - Latency: 1 cycle from the completing sample point to frame_valid.
// - Between frames, chars/dots hold their last value.
// - Errors are sticky until err_clear. If err_clear coincides with a new error, the error wins (flag stays 1).
// - A frame whose slots include code 31 is still published.
// - Inputs changing every cycle (never stable) produce no captures and no frames.
// - reset_n asserted mid-frame discards the partial mask and buffer immediately.
// TESTING
// 1. Drive the FPGA cycle with 8-cycle dwells: digit=1000 seg=8E, 0100 CE, 0010 BC, 0001 EE
//    -> frame_valid once after the 4th dwell.
//    -> chars = {15,17,16,10} (slot3..0), dots = 0, frame_changed = 1, frame_count = 1.
// 2. Repeat the identical sequence -> second frame_valid with frame_changed = 0 and frame_count = 2.
// 3. SETTLE_CYCLES=4, dwell of 3 cycles on slot 0 then 8 cycles on slots 1-3
//    -> slot 0 never captured and no frame_valid. Extending the dwell to 4 cycles completes the frame.
// 4. seg_digit = 0011 for 6 cycles -> err_onehot = 1, no capture.
//    Pulse err_clear -> 0. err_clear in the same cycle as a new violation -> stays 1.
// 5. seg = 0x02 (g only) on slot 2, others valid -> err_pattern = 1.
//    The frame publishes with chars[14:10] = 31. Seg = 0x01 -> code 18 with dots[slot] = 1.
// 6. Assert reset_n = 0 after 2 of 4 slots -> all outputs return to reset values.
//    After release, the full sequence yields frame_count = 1. Also check frame_count wrap with COUNT_W=2.

Source files
------------

// File: rtl/seven_seg_frame_decoder.sv
// rtl/seven_seg_frame_decoder.sv - rebuilds per-digit glyph codes from a multiplexed 7-segment bus
module seven_seg_frame_decoder #(
   parameter int N_DIGITS      = 4,
   parameter int SETTLE_CYCLES = 4,
   parameter int COUNT_W       = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [7:0]              seg_abcdefgh,
   input  logic [N_DIGITS-1:0]     seg_digit,
   input  logic                    err_clear,
   output logic [5*N_DIGITS-1:0]   chars,
   output logic [N_DIGITS-1:0]     dots,
   output logic                    frame_valid,
   output logic                    frame_changed,
   output logic [COUNT_W-1:0]      frame_count,
   output logic                    err_onehot,
   output logic                    err_pattern
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [4:0] CODE_SPACE = 5'd18;
   localparam logic [4:0] CODE_BAD   = 5'd31;

   logic [N_DIGITS-1:0]   prev_digit;
   logic [7:0]            prev_seg;
   logic [CNT_W-1:0]      stable_cnt;
   logic [CNT_W-1:0]      cnt_next;
   logic                  sampled;
   logic [N_DIGITS-1:0]   mask;
   logic [N_DIGITS-1:0]   mask_next;
   logic [5*N_DIGITS-1:0] buf_chars;
   logic [N_DIGITS-1:0]   buf_dots;
   logic [5*N_DIGITS-1:0] cap_chars;
   logic [N_DIGITS-1:0]   cap_dots;
   logic                  changed;
   logic                  sample;
   logic                  blank;
   logic                  onehot;
   logic                  capture;
   logic                  complete;
   logic                  bad_onehot;
   logic                  bad_pattern;
   logic [4:0]            code;

   function automatic logic [4:0] glyph(input logic [6:0] p);
      case (p)
         7'b1111110: glyph = 5'd0;
         7'b0110000: glyph = 5'd1;
         7'b1101101: glyph = 5'd2;
         7'b1111001: glyph = 5'd3;
         7'b0110011: glyph = 5'd4;
         7'b1011011: glyph = 5'd5;
         7'b1011111: glyph = 5'd6;
         7'b1110000: glyph = 5'd7;
         7'b1111111: glyph = 5'd8;
         7'b1111011: glyph = 5'd9;
         7'b1110111: glyph = 5'd10;
         7'b0011111: glyph = 5'd11;
         7'b1001110: glyph = 5'd12;
         7'b0111101: glyph = 5'd13;
         7'b1001111: glyph = 5'd14;
         7'b1000111: glyph = 5'd15;
         7'b1011110: glyph = 5'd16;
         7'b1100111: glyph = 5'd17;
         7'b0000000: glyph = CODE_SPACE;
         default:    glyph = CODE_BAD;
      endcase
   endfunction

   always_comb begin
      changed  = (seg_digit != prev_digit) || (seg_abcdefgh != prev_seg);
      cnt_next = changed ? '0 : ((stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1));
      // A change starts a fresh dwell, so the old dwell's sampled flag no longer applies.
      sample   = (cnt_next == CNT_MAX) && (changed || !sampled);
      blank    = (seg_digit == '0);
      onehot   = !blank && ((seg_digit & (seg_digit - N_DIGITS'(1))) == '0);
      code     = glyph(seg_abcdefgh[7:1]);
      capture     = sample && onehot;
      bad_onehot  = sample && !blank && !onehot;
      bad_pattern = capture && (code == CODE_BAD);
      cap_chars = buf_chars;
      cap_dots  = buf_dots;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (seg_digit[i]) begin
            cap_chars[5*i +: 5] = code;
            cap_dots[i]         = seg_abcdefgh[0];
         end
      end
      mask_next = mask | seg_digit;
      complete  = capture && (&mask_next);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev_digit    <= '0;
         prev_seg      <= '0;
         stable_cnt    <= '0;
         sampled       <= 1'b0;
         mask          <= '0;
         buf_chars     <= {N_DIGITS{CODE_SPACE}};
         buf_dots      <= '0;
         chars         <= {N_DIGITS{CODE_SPACE}};
         dots          <= '0;
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         frame_count   <= '0;
         err_onehot    <= 1'b0;
         err_pattern   <= 1'b0;
      end else begin
         prev_digit    <= seg_digit;
         prev_seg      <= seg_abcdefgh;
         stable_cnt    <= cnt_next;
         sampled       <= (sampled && !changed) || sample;
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         if (capture) begin
            buf_chars <= cap_chars;
            buf_dots  <= cap_dots;
            mask      <= complete ? '0 : mask_next;
         end
         if (complete) begin
            chars         <= cap_chars;
            dots          <= cap_dots;
            frame_valid   <= 1'b1;
            frame_changed <= (cap_chars != chars) || (cap_dots != dots);
            frame_count   <= frame_count + COUNT_W'(1);
         end
         // A new error in the clearing cycle keeps the flag set.
         err_onehot  <= (err_onehot && !err_clear) || bad_onehot;
         err_pattern <= (err_pattern && !err_clear) || bad_pattern;
      end
   end

endmodule

// File: tb/tb_seven_seg_frame_decoder.sv
// tb/tb_seven_seg_frame_decoder.sv - directed bench for seven_seg_frame_decoder
module tb_seven_seg_frame_decoder;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [7:0]  seg_abcdefgh;
   logic [3:0]  seg_digit;
   logic        err_clear;
   logic [19:0] chars, chars2;
   logic [3:0]  dots, dots2;
   logic        frame_valid, frame_valid2;
   logic        frame_changed, frame_changed2;
   logic [15:0] frame_count;
   logic [1:0]  frame_count2;
   logic        err_onehot, err_onehot2;
   logic        err_pattern, err_pattern2;

   int checks = 0;
   int fails  = 0;
   int fv_cnt = 0;
   logic last_changed = 1'b0;

   localparam logic [19:0] RESET_CHARS = {4{5'd18}};
   localparam logic [19:0] FPGA_CHARS  = {5'd15, 5'd17, 5'd16, 5'd10};
   localparam logic [19:0] BAD_CHARS   = {5'd15, 5'd31, 5'd16, 5'd18};

   seven_seg_frame_decoder #(.N_DIGITS(4), .SETTLE_CYCLES(4), .COUNT_W(16)) dut (
      .clock(clock), .reset_n(reset_n), .seg_abcdefgh(seg_abcdefgh), .seg_digit(seg_digit),
      .err_clear(err_clear), .chars(chars), .dots(dots), .frame_valid(frame_valid),
      .frame_changed(frame_changed), .frame_count(frame_count), .err_onehot(err_onehot),
      .err_pattern(err_pattern)
   );

   seven_seg_frame_decoder #(.N_DIGITS(4), .SETTLE_CYCLES(4), .COUNT_W(2)) dut2 (
      .clock(clock), .reset_n(reset_n), .seg_abcdefgh(seg_abcdefgh), .seg_digit(seg_digit),
      .err_clear(err_clear), .chars(chars2), .dots(dots2), .frame_valid(frame_valid2),
      .frame_changed(frame_changed2), .frame_count(frame_count2), .err_onehot(err_onehot2),
      .err_pattern(err_pattern2)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (frame_valid === 1'b1) begin
         fv_cnt++;
         last_changed = frame_changed;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [3:0] d, input logic [7:0] s, input int n);
      seg_digit    = d;
      seg_abcdefgh = s;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic fpga_frame();
      step(4'b1000, 8'h8E, 8);
      step(4'b0100, 8'hCE, 8);
      step(4'b0010, 8'hBC, 8);
      step(4'b0001, 8'hEE, 8);
      step(4'b0000, 8'h00, 4);
   endtask

   initial begin
      reset_n = 1'b0;
      err_clear = 1'b0;
      step(4'b0000, 8'h00, 2);
      chk("reset_chars", 32'(chars), 32'(RESET_CHARS));
      chk("reset_dots", 32'(dots), 32'd0);
      chk("reset_fv", 32'(frame_valid), 32'd0);
      chk("reset_count", 32'(frame_count), 32'd0);
      chk("reset_err_onehot", 32'(err_onehot), 32'd0);
      chk("reset_err_pattern", 32'(err_pattern), 32'd0);
      reset_n = 1'b1;

      fpga_frame();
      chk("t1_frames", 32'(fv_cnt), 32'd1);
      chk("t1_chars", 32'(chars), 32'(FPGA_CHARS));
      chk("t1_dots", 32'(dots), 32'd0);
      chk("t1_changed", 32'(last_changed), 32'd1);
      chk("t1_count", 32'(frame_count), 32'd1);

      fpga_frame();
      chk("t2_frames", 32'(fv_cnt), 32'd2);
      chk("t2_changed", 32'(last_changed), 32'd0);
      chk("t2_count", 32'(frame_count), 32'd2);

      step(4'b0000, 8'h00, 8);
      step(4'b0001, 8'hEE, 3);
      step(4'b0010, 8'hBC, 8);
      step(4'b0100, 8'hCE, 8);
      step(4'b1000, 8'h8E, 8);
      chk("t3_short_dwell_no_frame", 32'(fv_cnt), 32'd2);
      step(4'b0001, 8'hEE, 4);
      step(4'b0000, 8'h00, 4);
      chk("t3_frames", 32'(fv_cnt), 32'd3);
      chk("t3_count", 32'(frame_count), 32'd3);
      chk("t3_count_w2", 32'(frame_count2), 32'd3);
      chk("t3_changed", 32'(last_changed), 32'd0);

      step(4'b0011, 8'hEE, 6);
      chk("t4_err_onehot_set", 32'(err_onehot), 32'd1);
      chk("t4_no_frame", 32'(fv_cnt), 32'd3);
      err_clear = 1'b1;
      step(4'b0000, 8'h00, 1);
      err_clear = 1'b0;
      chk("t4_err_onehot_cleared", 32'(err_onehot), 32'd0);
      step(4'b0011, 8'hEE, 3);
      chk("t4_err_before_sample", 32'(err_onehot), 32'd0);
      err_clear = 1'b1;
      step(4'b0011, 8'hEE, 1);
      err_clear = 1'b0;
      chk("t4_err_wins_clear", 32'(err_onehot), 32'd1);
      chk("t4_err_pattern_clean", 32'(err_pattern), 32'd0);

      step(4'b1000, 8'h8E, 8);
      step(4'b0100, 8'h02, 8);
      step(4'b0010, 8'hBC, 8);
      step(4'b0001, 8'h01, 8);
      step(4'b0000, 8'h00, 4);
      chk("t5_err_pattern", 32'(err_pattern), 32'd1);
      chk("t5_frames", 32'(fv_cnt), 32'd4);
      chk("t5_chars", 32'(chars), 32'(BAD_CHARS));
      chk("t5_dots", 32'(dots), 32'b0001);
      chk("t5_changed", 32'(last_changed), 32'd1);
      chk("t5_count", 32'(frame_count), 32'd4);
      chk("t5_count_w2_wrap", 32'(frame_count2), 32'd0);

      step(4'b1000, 8'h8E, 8);
      step(4'b0100, 8'hCE, 8);
      reset_n = 1'b0;
      step(4'b0000, 8'h00, 2);
      chk("t6_reset_chars", 32'(chars), 32'(RESET_CHARS));
      chk("t6_reset_dots", 32'(dots), 32'd0);
      chk("t6_reset_count", 32'(frame_count), 32'd0);
      chk("t6_reset_err_onehot", 32'(err_onehot), 32'd0);
      chk("t6_reset_err_pattern", 32'(err_pattern), 32'd0);
      chk("t6_reset_fv", 32'(frame_valid), 32'd0);
      reset_n = 1'b1;
      for (int r = 0; r < 5; r++) begin
         step(4'b0001, 8'hEE, 1);
         step(4'b0010, 8'hBC, 1);
         step(4'b0100, 8'hCE, 1);
         step(4'b1000, 8'h8E, 1);
      end
      step(4'b0000, 8'h00, 4);
      chk("t6_unstable_no_frame", 32'(fv_cnt), 32'd4);
      step(4'b0010, 8'hBC, 8);
      step(4'b0001, 8'hEE, 8);
      step(4'b0000, 8'h00, 4);
      chk("t6_partial_discarded", 32'(fv_cnt), 32'd4);
      fpga_frame();
      chk("t6_frames", 32'(fv_cnt), 32'd5);
      chk("t6_count", 32'(frame_count), 32'd1);
      chk("t6_chars", 32'(chars), 32'(FPGA_CHARS));
      chk("t6_changed", 32'(last_changed), 32'd1);
      chk("t6_count_w2", 32'(frame_count2), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
